// File: rtl/decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// decode_queue_pkg
// Shared types and constants for the decode queue:
//   - RV32I/M major opcode constants and the two exact SYSTEM words
//   - opcode_out_t : decoded operation, NOP encoded as zero so cleared
//                    storage reads back as NOP
//   - dec_fields_t : everything decode produces from one instruction word
//   - dec_entry_t  : a full queue entry (decoded fields plus a 32-bit PC)
//   - writes_rd()  : which decoded operations architecturally write rd
// ---------------------------------------------------------------------------
package decode_queue_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct7 values that select operation families
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MEXT = 7'h01;

  // The only two legal SYSTEM encodings
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // NOP must stay at zero: reset clears storage and the head must read NOP.
  typedef enum logic [5:0] {
    NOP = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ECALL, EBREAK,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    ILLEGAL
  } opcode_out_t;

  typedef struct packed {
    opcode_out_t opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wr_en;
  } dec_fields_t;

  // Packed structs cannot take a module parameter, so the entry view fixes
  // the PC at 32 bits. The queue keeps PCs in their own PC_W-wide array so
  // it is not tied to this width.
  localparam int ENTRY_PC_W = 32;

  typedef struct packed {
    opcode_out_t           opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  wr_en;
    logic [ENTRY_PC_W-1:0] pc;
  } dec_entry_t;

  // Operations that produce a register result. Stores, branches, SYSTEM,
  // NOP and ILLEGAL are deliberately absent.
  function automatic logic writes_rd(input opcode_out_t op);
    return op inside {LUI, AUIPC, JAL, JALR,
                      LB, LH, LW, LBU, LHU,
                      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
                      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
                      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/decode_queue_core.sv
// ---------------------------------------------------------------------------
// decode_core
// Purely combinational RV32I(+M) decoder producing the queue entry fields.
//   Parameters : EN_M - 1 decodes funct7=01 R-type as MUL..REMU, 0 as ILLEGAL
//   instr  in  32            raw instruction word
//   fields out dec_fields_t  {opcode, rd, rs1, rs2, wr_en}
// Register indices are passed through from their fixed bit positions even
// for formats that do not use them; wr_en qualifies whether rd matters.
// ---------------------------------------------------------------------------
module decode_core
  import decode_queue_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] instr,
  output dec_fields_t fields
);

  logic [6:0]  funct7;
  logic [2:0]  funct3;
  opcode_out_t opcode;

  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];

  // Opcode selection. Everything starts as ILLEGAL and only the encodings
  // that are explicitly recognised below are promoted to a real operation.
  always_comb begin
    opcode = ILLEGAL;
    case (instr[6:0])
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  opcode = ADD;
            3'b001:  opcode = SLL;
            3'b010:  opcode = SLT;
            3'b011:  opcode = SLTU;
            3'b100:  opcode = XOR;
            3'b101:  opcode = SRL;
            3'b110:  opcode = OR;
            default: opcode = AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      opcode = SUB;
          else if (funct3 == 3'b101) opcode = SRA;
        end else if (funct7 == F7_MEXT && EN_M) begin
          case (funct3)
            3'b000:  opcode = MUL;
            3'b001:  opcode = MULH;
            3'b010:  opcode = MULHSU;
            3'b011:  opcode = MULHU;
            3'b100:  opcode = DIV;
            3'b101:  opcode = DIVU;
            3'b110:  opcode = REM;
            default: opcode = REMU;
          endcase
        end
      end
      OP_IMM: begin
        case (funct3)
          3'b000: opcode = ADDI;
          3'b010: opcode = SLTI;
          3'b011: opcode = SLTIU;
          3'b100: opcode = XORI;
          3'b110: opcode = ORI;
          3'b111: opcode = ANDI;
          3'b001: if (funct7 == F7_BASE) opcode = SLLI;
          default: begin
            // funct3 = 101: the shift kind is carried in funct7
            if (funct7 == F7_BASE)     opcode = SRLI;
            else if (funct7 == F7_ALT) opcode = SRAI;
          end
        endcase
      end
      OP_LOAD: begin
        case (funct3)
          3'b000:  opcode = LB;
          3'b001:  opcode = LH;
          3'b010:  opcode = LW;
          3'b100:  opcode = LBU;
          3'b101:  opcode = LHU;
          default: opcode = ILLEGAL;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000:  opcode = SB;
          3'b001:  opcode = SH;
          3'b010:  opcode = SW;
          default: opcode = ILLEGAL;
        endcase
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  opcode = BEQ;
          3'b001:  opcode = BNE;
          3'b100:  opcode = BLT;
          3'b101:  opcode = BGE;
          3'b110:  opcode = BLTU;
          3'b111:  opcode = BGEU;
          default: opcode = ILLEGAL;
        endcase
      end
      OP_LUI:   opcode = LUI;
      OP_AUIPC: opcode = AUIPC;
      OP_JAL:   opcode = JAL;
      OP_JALR:  if (funct3 == 3'b000) opcode = JALR;
      OP_FENCE: opcode = NOP;
      OP_SYSTEM: begin
        // Only the two exact words are accepted; any stray bit is illegal.
        if (instr == INSTR_ECALL)       opcode = ECALL;
        else if (instr == INSTR_EBREAK) opcode = EBREAK;
      end
      default: opcode = ILLEGAL;
    endcase
  end

  // Pack the entry. Writes to x0 are dropped here so the consumer can use
  // wr_en directly without re-checking rd.
  always_comb begin
    fields.opcode = opcode;
    fields.rd     = instr[11:7];
    fields.rs1    = instr[19:15];
    fields.rs2    = instr[24:20];
    fields.wr_en  = writes_rd(opcode) && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Decode stage between fetch and ID/EX: decodes each accepted instruction
// and buffers the result in a DEPTH-entry FIFO.
//   Parameters : DEPTH (power of two, >= 2), EN_M, PC_W
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         fetch handshake; in_ready = count < DEPTH
//   in_instr, in_pc           instruction word and its PC
//   flush                     drop every entry, including a same-cycle push
//   out_valid/out_ready       consumer handshake; out_valid = count != 0
//   out_opcode .. out_pc      head entry fields, out_illegal = ILLEGAL head
//   count                     occupancy
// All out_* come straight from storage; no in_* reaches an output in the
// same cycle.
// ---------------------------------------------------------------------------
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit EN_M  = 1'b1,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output opcode_out_t                out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic                       out_wr_en,
  output logic                       out_illegal,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  dec_fields_t           dec;
  dec_fields_t           mem    [DEPTH];
  logic [PC_W-1:0]       pc_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  decode_core #(
    .EN_M (EN_M)
  ) u_core (
    .instr  (in_ready ? in_instr : in_instr),
    .fields (dec)
  );

  // Handshake qualification. in_ready depends on count alone, so a pop in
  // a full cycle never opens room for a push in that same cycle. Flush
  // masks both directions so the flush cycle changes nothing but the reset
  // of the pointers.
  always_comb begin
    in_ready  = (count < CNT_W'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // FIFO storage, pointers and occupancy. Pointers are exactly log2(DEPTH)
  // wide so they wrap on their own. Storage is cleared on reset only, so
  // the head reads NOP/zero after reset; after a flush the stale head is
  // still visible but out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]    <= dec;
        pc_mem[wr_ptr] <= in_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry presentation
  always_comb begin
    out_opcode  = mem[rd_ptr].opcode;
    out_rd      = mem[rd_ptr].rd;
    out_rs1     = mem[rd_ptr].rs1;
    out_rs2     = mem[rd_ptr].rs2;
    out_wr_en   = mem[rd_ptr].wr_en;
    out_illegal = (mem[rd_ptr].opcode == ILLEGAL);
    out_pc      = pc_mem[rd_ptr];
  end

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
// Drives two decode_queue instances (EN_M=1 and EN_M=0) with the same
// stimulus and compares both against a queue-of-instructions reference that
// decodes from the ISA tables at the moment an entry reaches the head.
// ---------------------------------------------------------------------------
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NDIR  = 10;
  localparam int CHK_NONE  = -1;
  localparam int CHK_EMPTY = 100;
  localparam int CHK_FULL  = 101;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_ready;

  logic            a_in_ready, a_out_valid, a_out_wr_en, a_out_illegal;
  opcode_out_t     a_out_opcode;
  logic [4:0]      a_out_rd, a_out_rs1, a_out_rs2;
  logic [PC_W-1:0] a_out_pc;
  logic [CW-1:0]   a_count;

  logic            b_in_ready, b_out_valid, b_out_wr_en, b_out_illegal;
  opcode_out_t     b_out_opcode;
  logic [4:0]      b_out_rd, b_out_rs1, b_out_rs2;
  logic [PC_W-1:0] b_out_pc;
  logic [CW-1:0]   b_count;

  int errors = 0;
  int checks = 0;

  // Reference contents: raw words and PCs in push order
  logic [31:0] mq  [$];
  logic [31:0] mpc [$];

  // Directed words with their expected decode for EN_M=1 (A) and EN_M=0 (B)
  logic [31:0] dir_word [NDIR] = '{32'h00A302B3, 32'h02A302B3, 32'h00A32023,
                                   32'h00000073, 32'h00200073, 32'h00000000,
                                   32'h00100073, 32'h0FF0000F, 32'h40A302B3,
                                   32'h40A312B3};
  opcode_out_t dir_op_a [NDIR] = '{ADD, MUL, SW, ECALL, ILLEGAL, ILLEGAL,
                                   EBREAK, NOP, SUB, ILLEGAL};
  opcode_out_t dir_op_b [NDIR] = '{ADD, ILLEGAL, SW, ECALL, ILLEGAL, ILLEGAL,
                                   EBREAK, NOP, SUB, ILLEGAL};
  bit          dir_we_a [NDIR] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  bit          dir_we_b [NDIR] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .EN_M(1'b1), .PC_W(PC_W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1),
    .out_rs2(a_out_rs2), .out_wr_en(a_out_wr_en),
    .out_illegal(a_out_illegal), .out_pc(a_out_pc), .count(a_count)
  );

  decode_queue #(.DEPTH(DEPTH), .EN_M(1'b0), .PC_W(PC_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_wr_en(b_out_wr_en),
    .out_illegal(b_out_illegal), .out_pc(b_out_pc), .count(b_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Table-driven ISA decode, looked up per field rather than per encoding
  function automatic opcode_out_t modelDecode(input logic [31:0] w, input bit en_m);
    opcode_out_t r_base [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    opcode_out_t m_ops  [8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    opcode_out_t i_ops  [8] = '{ADDI, ILLEGAL, SLTI, SLTIU, XORI, ILLEGAL, ORI, ANDI};
    opcode_out_t ld_ops [8] = '{LB, LH, LW, ILLEGAL, LBU, LHU, ILLEGAL, ILLEGAL};
    opcode_out_t st_ops [8] = '{SB, SH, SW, ILLEGAL, ILLEGAL, ILLEGAL, ILLEGAL, ILLEGAL};
    opcode_out_t br_ops [8] = '{BEQ, BNE, ILLEGAL, ILLEGAL, BLT, BGE, BLTU, BGEU};
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00) return r_base[f3];
        if (f7 == 7'h20) return (f3 == 3'd0) ? SUB : ((f3 == 3'd5) ? SRA : ILLEGAL);
        if (f7 == 7'h01 && en_m) return m_ops[f3];
        return ILLEGAL;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? SLLI : ILLEGAL;
        if (f3 == 3'd5) return (f7 == 7'h00) ? SRLI : ((f7 == 7'h20) ? SRAI : ILLEGAL);
        return i_ops[f3];
      end
      7'h03: return ld_ops[f3];
      7'h23: return st_ops[f3];
      7'h63: return br_ops[f3];
      7'h37: return LUI;
      7'h17: return AUIPC;
      7'h6F: return JAL;
      7'h67: return (f3 == 3'd0) ? JALR : ILLEGAL;
      7'h0F: return NOP;
      7'h73: return (w == 32'h73) ? ECALL : ((w == 32'h100073) ? EBREAK : ILLEGAL);
      default: return ILLEGAL;
    endcase
  endfunction

  function automatic bit modelWrites(input opcode_out_t op, input logic [4:0] rd);
    if (op inside {SB, SH, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU,
                   ECALL, EBREAK, NOP, ILLEGAL})
      return 1'b0;
    return rd != 5'd0;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h00};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 12) w[6:0] = ops[sel];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1)
      w = ($urandom_range(0, 1) == 1) ? 32'h00000073 : 32'h00100073;
    return w;
  endfunction

  task automatic checkDut(input string name, input bit en_m, input logic ir,
                          input logic ov, input logic [CW-1:0] cnt,
                          input opcode_out_t op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic we, input logic ill,
                          input logic [PC_W-1:0] pc);
    int n;
    opcode_out_t eop;
    logic [31:0] w;
    n = mq.size();
    checkOutput({name, "_in_ready"}, ir, n < DEPTH);
    checkOutput({name, "_out_valid"}, ov, n != 0);
    checkOutput({name, "_count"}, cnt, n);
    if (n != 0) begin
      w   = mq[0];
      eop = modelDecode(w, en_m);
      checkOutput({name, "_opcode"}, op, eop);
      checkOutput({name, "_rd"}, rd, w[11:7]);
      checkOutput({name, "_rs1"}, rs1, w[19:15]);
      checkOutput({name, "_rs2"}, rs2, w[24:20]);
      checkOutput({name, "_wr_en"}, we, modelWrites(eop, w[11:7]));
      checkOutput({name, "_illegal"}, ill, eop == ILLEGAL);
      checkOutput({name, "_pc"}, pc, mpc[0]);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_valid"}, a_out_valid, 0);
    checkOutput({name, "_ready"}, a_in_ready, 1);
    checkOutput({name, "_count"}, a_count, 0);
    checkOutput({name, "_opcode"}, a_out_opcode, NOP);
    checkOutput({name, "_regs"}, {a_out_rd, a_out_rs1, a_out_rs2}, 0);
    checkOutput({name, "_wr_en"}, a_out_wr_en, 0);
    checkOutput({name, "_illegal"}, a_out_illegal, 0);
    checkOutput({name, "_pc"}, a_out_pc, 0);
    checkOutput({name, "_b_valid"}, b_out_valid, 0);
    checkOutput({name, "_b_opcode"}, b_out_opcode, NOP);
  endtask

  // One clock cycle: drive, sample mid-cycle against the reference, then
  // advance the reference by the handshake rules for this cycle's inputs.
  task automatic applyStimulus(input logic iv, input logic [31:0] instr,
                               input logic [PC_W-1:0] pc, input logic fl,
                               input logic ordy, input int chk);
    bit push, pop;
    in_valid  = iv;
    in_instr  = instr;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    checkDut("a", 1'b1, a_in_ready, a_out_valid, a_count, a_out_opcode,
             a_out_rd, a_out_rs1, a_out_rs2, a_out_wr_en, a_out_illegal, a_out_pc);
    checkDut("b", 1'b0, b_in_ready, b_out_valid, b_count, b_out_opcode,
             b_out_rd, b_out_rs1, b_out_rs2, b_out_wr_en, b_out_illegal, b_out_pc);
    if (chk >= 0 && chk < NDIR) begin
      checkOutput("dir_a_opcode", a_out_opcode, dir_op_a[chk]);
      checkOutput("dir_b_opcode", b_out_opcode, dir_op_b[chk]);
      checkOutput("dir_a_wr_en", a_out_wr_en, dir_we_a[chk]);
      checkOutput("dir_b_wr_en", b_out_wr_en, dir_we_b[chk]);
      checkOutput("dir_b_illegal", b_out_illegal, dir_op_b[chk] == ILLEGAL);
      checkOutput("dir_a_pc", a_out_pc, 32'h100 + 32'(chk * 4));
      if (chk == 0)
        checkOutput("dir_add_fields", {a_out_rd, a_out_rs1, a_out_rs2},
                    {5'd5, 5'd6, 5'd10});
    end else if (chk == CHK_EMPTY) begin
      checkOutput("flush_count", a_count, 0);
      checkOutput("flush_valid", a_out_valid, 0);
      checkOutput("flush_ready", a_in_ready, 1);
    end else if (chk == CHK_FULL) begin
      checkOutput("full_count", a_count, DEPTH);
      checkOutput("full_ready", a_in_ready, 0);
    end
    push = iv && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() != 0) && ordy && !fl;
    if (fl) begin
      mq.delete();
      mpc.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        void'(mpc.pop_front());
      end
      if (push) begin
        mq.push_back(instr);
        mpc.push_back(pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomTraffic(input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, CHK_NONE);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++)
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, CHK_NONE);
    if (mq.size() != 0) checkOutput("drain_bound", mq.size(), 0);
  endtask

  task automatic fillTo(input int target);
    for (int i = 0; i < 2 * DEPTH && mq.size() < target; i++)
      applyStimulus(1'b1, randInstr(), $urandom, 1'b0, 1'b0, CHK_NONE);
    if (mq.size() != target) checkOutput("fill_bound", mq.size(), target);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    checkReset("rst_hold");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkReset("rst_release");

    // Directed decode: push each word, check it at the head, then pop it
    for (int i = 0; i < NDIR; i++) begin
      applyStimulus(1'b1, dir_word[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0, CHK_NONE);
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, i);
    end

    randomTraffic(200);

    // Fill with the consumer stalled, offer one more word while popping,
    // then drain in order across the pointer wrap
    fillTo(DEPTH);
    applyStimulus(1'b1, 32'h00B50533, 32'hBAD0, 1'b0, 1'b1, CHK_FULL);
    drain();

    // Flush with a push in the same cycle
    fillTo(2);
    applyStimulus(1'b1, 32'h00C586B3, 32'hF1F0, 1'b1, 1'b1, CHK_NONE);
    applyStimulus(1'b1, 32'h00D60733, 32'h2000, 1'b0, 1'b0, CHK_EMPTY);
    applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, CHK_NONE);

    randomTraffic(200);

    // Asynchronous reset in the middle of a cycle with three entries held
    drain();
    fillTo(3);
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    checkReset("rst_mid");
    mq.delete();
    mpc.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h00A302B3, 32'h100, 1'b0, 1'b0, CHK_NONE);
    applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, 0);

    randomTraffic(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
